// File: rtl/keypad_matrix_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_ctrl
// Brief    : N-pad x K-key keypad front end: synchronise and debounce raw
//            keys, latch the CPU key select, drive one EF flag per pad.
// Revision : 1.0  initial release
// ============================================================================
module keypad_matrix_ctrl #(
    parameter int NUM_PADS      = 2,
    parameter int KEYS          = 10,
    parameter int SHARED_LATCH  = 1,
    parameter int LATCH_PORT    = 1,
    parameter int DEB_DIV       = 1760,
    parameter int DEB_MAX       = 3,
    parameter int EF_ACTIVE_LOW = 0
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NUM_PADS*KEYS-1:0] key_raw,
    input  logic [2:0]               io_n,
    input  logic                     io_out,
    input  logic [7:0]               cpu_dout,
    output logic [NUM_PADS-1:0]      ef_keys,
    output logic [4*NUM_PADS-1:0]    keylatch,
    output logic                     key_any,
    output logic                     key_evt
);

    localparam int          c_NUM_KEYS = NUM_PADS * KEYS;
    localparam logic [15:0] c_DIV_LAST = 16'(DEB_DIV - 1);
    localparam logic [2:0]  c_MAX      = 3'(DEB_MAX);
    localparam logic [2:0]  c_PORT0    = 3'(LATCH_PORT);
    localparam logic        c_EF_POL   = (EF_ACTIVE_LOW != 0);

    logic [c_NUM_KEYS-1:0] r_sync1;
    logic [c_NUM_KEYS-1:0] r_sync2;
    logic [c_NUM_KEYS-1:0] w_deb;
    logic [c_NUM_KEYS-1:0] r_deb_prev;
    logic [15:0]           r_pre;
    logic                  w_tick;
    logic                  r_any;
    logic                  r_evt;
    logic                  w_unused;

    // Only the low nibble of the OUT data selects a key.
    assign w_unused = ^cpu_dout[7:4];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_pre == c_DIV_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    for (genvar gk = 0; gk < c_NUM_KEYS; gk++) begin : g_key
        logic [2:0] r_cnt;
        logic [2:0] w_cnt_nxt;
        logic       r_state;

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (r_sync2[gk]) begin
                if (r_cnt < c_MAX) begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end else if (r_cnt != 3'd0) begin
                w_cnt_nxt = r_cnt - 3'd1;
            end
        end

        // State only flips at the rails; in between it holds (hysteresis).
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_cnt   <= '0;
                r_state <= 1'b0;
            end else if (w_tick) begin
                r_cnt <= w_cnt_nxt;
                if (w_cnt_nxt == c_MAX) begin
                    r_state <= 1'b1;
                end else if (w_cnt_nxt == 3'd0) begin
                    r_state <= 1'b0;
                end
            end
        end

        assign w_deb[gk] = r_state;
    end

    for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_pad
        logic [3:0]  r_latch;
        logic        r_ef;
        logic        w_ld;
        logic [15:0] w_pad_keys;
        logic        w_hit;

        if (SHARED_LATCH != 0) begin : g_shared
            assign w_ld = io_out && (io_n == c_PORT0);
        end else begin : g_own
            localparam logic [2:0] c_PAD_PORT = 3'(LATCH_PORT + gp);
            assign w_ld = io_out && (io_n == c_PAD_PORT);
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_latch <= '0;
            end else if (w_ld) begin
                r_latch <= cpu_dout[3:0];
            end
        end

        // Zero padding above KEYS makes an out-of-range select read as released.
        assign w_pad_keys = 16'(w_deb[gp*KEYS +: KEYS]);
        assign w_hit      = w_pad_keys[r_latch];

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_ef <= c_EF_POL;
            end else begin
                r_ef <= w_hit ^ c_EF_POL;
            end
        end

        assign keylatch[4*gp +: 4] = r_latch;
        assign ef_keys[gp]         = r_ef;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_deb_prev <= '0;
            r_any      <= 1'b0;
            r_evt      <= 1'b0;
        end else begin
            r_deb_prev <= w_deb;
            r_any      <= |w_deb;
            r_evt      <= (w_deb != r_deb_prev);
        end
    end

    assign key_any = r_any;
    assign key_evt = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_matrix_ctrl
// Brief    : Directed bench for keypad_matrix_ctrl: a shared-latch active-high
//            instance and a per-pad-latch active-low instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_matrix_ctrl;

    localparam int NP   = 2;
    localparam int NK   = 10;
    localparam int DIV  = 4;
    localparam int DMAX = 3;
    localparam int NB   = NP * NK;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [NB-1:0]   key_raw_a, key_raw_b;
    logic [2:0]      io_n_a, io_n_b;
    logic            io_out_a, io_out_b;
    logic [7:0]      dout_a, dout_b;
    logic [NP-1:0]   ef_a, ef_b;
    logic [4*NP-1:0] latch_a, latch_b;
    logic            any_a, any_b, evt_a, evt_b;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    typedef struct {
        logic [2:0] n;
        logic       out;
        logic [7:0] d;
        int         hold;
        logic [7:0] exp_latch;
        logic [1:0] exp_ef;
    } vec_t;

    vec_t tbl [11];

    keypad_matrix_ctrl #(
        .NUM_PADS(NP), .KEYS(NK), .SHARED_LATCH(1), .LATCH_PORT(1),
        .DEB_DIV(DIV), .DEB_MAX(DMAX), .EF_ACTIVE_LOW(0)
    ) u_dut_a (
        .clk_sys(clk_sys), .reset(reset), .key_raw(key_raw_a),
        .io_n(io_n_a), .io_out(io_out_a), .cpu_dout(dout_a),
        .ef_keys(ef_a), .keylatch(latch_a), .key_any(any_a), .key_evt(evt_a)
    );

    keypad_matrix_ctrl #(
        .NUM_PADS(NP), .KEYS(NK), .SHARED_LATCH(0), .LATCH_PORT(1),
        .DEB_DIV(DIV), .DEB_MAX(DMAX), .EF_ACTIVE_LOW(1)
    ) u_dut_b (
        .clk_sys(clk_sys), .reset(reset), .key_raw(key_raw_b),
        .io_n(io_n_b), .io_out(io_out_b), .cpu_dout(dout_b),
        .ef_keys(ef_b), .keylatch(latch_b), .key_any(any_b), .key_evt(evt_b)
    );

    always #5 clk_sys = ~clk_sys;

    // Edges since reset release; the prescaler wraps on every DIV-th edge.
    always @(posedge clk_sys) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, ncyc=%0d", ncyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int next_tick(input int n);
        int m = n;
        while (m % DIV != 0) m++;
        return m;
    endfunction

    task automatic goto(input int n);
        int guard = 0;
        while (ncyc < n && guard < 2000) begin
            @(negedge clk_sys);
            guard++;
        end
        if (ncyc != n) begin
            total++;
            bad++;
            $display("FAIL goto: at %0d want %0d", ncyc, n);
        end
    endtask

    // Edge at which ef/evt reflect a key change applied at edge count p.
    function automatic int settle_edge(input int p);
        return next_tick(p + 3) + DMAX * DIV - DIV + 1;
    endfunction

    task automatic watch(input string nm, input bit use_b, input int bitp, input int at,
                         input logic pre, input logic post, input int stop);
        int evts = 0;
        logic [NP-1:0] e;
        while (ncyc < stop) begin
            @(negedge clk_sys);
            e = use_b ? ef_b : ef_a;
            if (use_b ? evt_b : evt_a) evts++;
            if (ncyc == at - 1) chk({nm, "_before"}, 32'(e[bitp]), 32'(pre));
            if (ncyc == at)     chk({nm, "_after"},  32'(e[bitp]), 32'(post));
        end
        chk({nm, "_evt_pulses"}, evts, 1);
    endtask

    task automatic out_b(input string nm, input logic [2:0] n, input logic [7:0] d,
                         input logic [7:0] exp_l, input logic [1:0] exp_e);
        io_n_b = n; dout_b = d; io_out_b = 1'b1;
        @(negedge clk_sys);
        io_out_b = 1'b0;
        @(negedge clk_sys);
        chk({nm, "_latch"}, latch_b, exp_l);
        chk({nm, "_ef"}, ef_b, exp_e);
    endtask

    initial begin
        int r, q, cnt_ef, cnt_evt;

        tbl[0]  = '{3'd1, 1'b1, 8'h0C, 1, 8'hCC, 2'b00};
        tbl[1]  = '{3'd1, 1'b1, 8'h09, 1, 8'h99, 2'b11};
        tbl[2]  = '{3'd2, 1'b1, 8'h03, 1, 8'h99, 2'b11};
        tbl[3]  = '{3'd1, 1'b0, 8'h03, 1, 8'h99, 2'b11};
        tbl[4]  = '{3'd1, 1'b1, 8'h03, 1, 8'h33, 2'b10};
        tbl[5]  = '{3'd1, 1'b1, 8'h07, 3, 8'h77, 2'b01};
        tbl[6]  = '{3'd1, 1'b1, 8'hA0, 1, 8'h00, 2'b11};
        tbl[7]  = '{3'd1, 1'b1, 8'h0A, 1, 8'hAA, 2'b00};
        tbl[8]  = '{3'd1, 1'b1, 8'h0F, 2, 8'hFF, 2'b00};
        tbl[9]  = '{3'd0, 1'b1, 8'h05, 1, 8'hFF, 2'b00};
        tbl[10] = '{3'd1, 1'b1, 8'h00, 1, 8'h00, 2'b11};

        reset = 1'b1;
        key_raw_a = '1; key_raw_b = '1;
        io_n_a = 3'd1; io_out_a = 1'b1; dout_a = 8'h05;
        io_n_b = 3'd1; io_out_b = 1'b1; dout_b = 8'h03;

        // Reset with everything pressed and OUT strobing
        repeat (3) @(negedge clk_sys);
        chk("rst_ef_a", ef_a, 2'b00);
        chk("rst_latch_a", latch_a, 8'h00);
        chk("rst_any_a", any_a, 1'b0);
        chk("rst_evt_a", evt_a, 1'b0);
        chk("rst_ef_b", ef_b, 2'b11);
        chk("rst_latch_b", latch_b, 8'h00);
        repeat (DMAX * DIV + 2) @(negedge clk_sys);
        chk("rst_hold_ef_a", ef_a, 2'b00);
        chk("rst_hold_latch_a", latch_a, 8'h00);
        chk("rst_hold_any_a", any_a, 1'b0);
        chk("rst_hold_evt_a", evt_a, 1'b0);
        chk("rst_hold_ef_b", ef_b, 2'b11);
        chk("rst_hold_any_b", any_b, 1'b0);

        key_raw_a = '0; key_raw_b = '0;
        io_out_a = 1'b0; io_out_b = 1'b0;
        reset = 1'b0;

        // Press pad0 key5 with latch 5
        goto(3);
        io_n_a = 3'd1; dout_a = 8'h05; io_out_a = 1'b1;
        @(negedge clk_sys);
        io_out_a = 1'b0;
        @(negedge clk_sys);
        chk("t2_latch", latch_a, 8'h55);
        chk("t2_ef_idle", ef_a, 2'b00);
        goto(6);
        key_raw_a[5] = 1'b1;
        r = settle_edge(ncyc);
        chk("t2_latency", r - 6, 15);
        watch("t2_press", 1'b0, 0, r, 1'b0, 1'b1, r + 2);
        chk("t2_ef1_low", ef_a[1], 1'b0);
        chk("t2_any", any_a, 1'b1);

        // Glitch on pad1 key2 spanning one tick, then a real press and release
        io_n_a = 3'd1; dout_a = 8'h02; io_out_a = 1'b1;
        @(negedge clk_sys);
        io_out_a = 1'b0;
        @(negedge clk_sys);
        chk("t3_latch", latch_a, 8'h22);
        chk("t3_ef_idle", ef_a, 2'b00);
        goto(29);
        key_raw_a[12] = 1'b1;
        goto(31);
        key_raw_a[12] = 1'b0;
        cnt_ef = 0; cnt_evt = 0;
        while (ncyc < 44) begin
            @(negedge clk_sys);
            if (ef_a[1]) cnt_ef++;
            if (evt_a) cnt_evt++;
        end
        chk("t3_glitch_ef", cnt_ef, 0);
        chk("t3_glitch_evt", cnt_evt, 0);
        key_raw_a[12] = 1'b1;
        r = settle_edge(ncyc);
        watch("t3_rise", 1'b0, 1, r, 1'b0, 1'b1, r + 2);
        key_raw_a[12] = 1'b0;
        r = settle_edge(ncyc);
        watch("t3_fall", 1'b0, 1, r, 1'b1, 1'b0, r + 2);
        chk("t3_any_kept", any_a, 1'b1);

        // All keys pressed except pad0 key3 and pad1 key7, then latch table
        key_raw_a = 20'hDFFF7;
        goto(settle_edge(ncyc) + 2);
        for (int i = 0; i < 11; i++) begin
            io_n_a = tbl[i].n; io_out_a = tbl[i].out; dout_a = tbl[i].d;
            repeat (tbl[i].hold) @(negedge clk_sys);
            io_out_a = 1'b0;
            @(negedge clk_sys);
            chk($sformatf("vec%0d_latch", i), latch_a, tbl[i].exp_latch);
            chk($sformatf("vec%0d_ef", i), ef_a, tbl[i].exp_ef);
            chk($sformatf("vec%0d_evt", i), evt_a, 1'b0);
        end
        chk("t4_any", any_a, 1'b1);

        // Per-pad latches, active-low EF
        out_b("b_port1", 3'd1, 8'h03, 8'h03, 2'b11);
        out_b("b_port2", 3'd2, 8'h07, 8'h73, 2'b11);
        out_b("b_port4", 3'd4, 8'h01, 8'h73, 2'b11);
        out_b("b_port0", 3'd0, 8'h01, 8'h73, 2'b11);
        key_raw_b[3] = 1'b1;
        r = settle_edge(ncyc);
        watch("b_press", 1'b1, 0, r, 1'b1, 1'b0, r + 2);
        chk("b_any", any_b, 1'b1);

        // Latch write lands on the same edge the debounced state sets
        q = ncyc;
        key_raw_b[15] = 1'b1;
        r = settle_edge(q) - 1;
        goto(r - 1);
        io_n_b = 3'd2; dout_b = 8'h05; io_out_b = 1'b1;
        @(negedge clk_sys);
        io_out_b = 1'b0;
        chk("b_same_latch", latch_b, 8'h53);
        chk("b_same_ef_old", ef_b, 2'b10);
        @(negedge clk_sys);
        chk("b_same_ef_new", ef_b, 2'b00);
        chk("b_same_evt", evt_b, 1'b1);
        @(negedge clk_sys);
        chk("b_same_evt_end", evt_b, 1'b0);
        out_b("b_oor", 3'd2, 8'h0C, 8'hC3, 2'b10);
        out_b("b_pad0_9", 3'd1, 8'hF9, 8'hC9, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
